// File: rtl/cosim_pkg.sv
// Shared types for the cosim commit queue.
//   INST_LEN       instruction width carried per entry
//   ENTRY_XLEN     data/pc width of a stored entry (must match the queue's XLEN)
//   cosim_entry_t  one queued commit or trap; a trap reuses wdata for its cause
//   popcount       ones count of a small valid vector (up to POPCNT_W bits)
package cosim_pkg;

   localparam int INST_LEN   = 32;
   localparam int ENTRY_XLEN = 64;
   localparam int POPCNT_W   = 8;

   typedef struct packed {
      logic                  is_trap;
      logic [ENTRY_XLEN-1:0] pc;
      logic [INST_LEN-1:0]   inst;
      logic [ENTRY_XLEN-1:0] wdata;   // trap cause when is_trap
      logic [ENTRY_XLEN-1:0] mstatus;
      logic                  check;
   } cosim_entry_t;

   function automatic logic [3:0] popcount(input logic [POPCNT_W-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < POPCNT_W; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/cosim_lane_compactor.sv
// Turns sparse commit lanes plus an optional trap into a dense slot list.
//   valid_i  per-lane commit valid, holes allowed
//   xcpt_i   trap this cycle; always ordered after every same-cycle commit
//   n_o      number of entries to enqueue (commits + trap)
//   src_o    per slot: source lane index, or CW for the trap slot
module cosim_lane_compactor
   import cosim_pkg::*;
#(
   parameter  int CW    = 3,
   localparam int IDX_W = $clog2(CW + 1),
   localparam int CNT_W = $clog2(CW + 2)
) (
   input  logic [CW-1:0]           valid_i,
   input  logic                    xcpt_i,
   output logic [CNT_W-1:0]        n_o,
   output logic [CW:0][IDX_W-1:0]  src_o
);

   logic [IDX_W-1:0] cnt;

   always_comb begin
      src_o = '0;
      cnt   = '0;
      for (int i = 0; i < CW; i++) begin
         if (valid_i[i]) begin
            src_o[cnt] = IDX_W'(i);
            cnt        = cnt + IDX_W'(1);
         end
      end
      // trap lands right after the last commit, so it is always the youngest
      if (xcpt_i) src_o[cnt] = IDX_W'(CW);
      n_o = CNT_W'(popcount(POPCNT_W'(valid_i))) + CNT_W'(xcpt_i);
   end

endmodule

// File: rtl/cosim_commit_queue.sv
// Elastic buffer in front of the cosim blackbox. Compacts sparse commit lanes
// and traps into program order and replays them as dense lanes.
//   clock, reset        clock; synchronous active-low reset
//   in_*                per-lane commit fields, in_xcpt/in_cause trap event, hartid
//   out_valid           dense lane valids (low lanes only)
//   out_*               head entry fields, zero on invalid lanes
//   out_int_xcpt/cause  trap presented this cycle
//   stall               fewer than CW+1 free entries
//   overflow            sticky: a whole input cycle was dropped
//   level               occupied entries
module cosim_commit_queue
   import cosim_pkg::*;
#(
   parameter int COMMIT_WIDTH = 3,
   parameter int XLEN         = 64,
   parameter int DEPTH        = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [COMMIT_WIDTH-1:0]          in_valid,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     in_pc,
   input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     in_wdata,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     in_mstatus,
   input  logic [COMMIT_WIDTH-1:0]          in_check,
   input  logic                             in_xcpt,
   input  logic [XLEN-1:0]                  in_cause,
   input  logic [XLEN-1:0]                  hartid,
   output logic [COMMIT_WIDTH-1:0]          out_valid,
   output logic [XLEN-1:0]                  out_hartid,
   output logic [XLEN*COMMIT_WIDTH-1:0]     out_pc,
   output logic [INST_LEN*COMMIT_WIDTH-1:0] out_inst,
   output logic [XLEN*COMMIT_WIDTH-1:0]     out_wdata,
   output logic [XLEN*COMMIT_WIDTH-1:0]     out_mstatus,
   output logic [COMMIT_WIDTH-1:0]          out_check,
   output logic                             out_int_xcpt,
   output logic [XLEN-1:0]                  out_cause,
   output logic                             stall,
   output logic                             overflow,
   output logic [$clog2(DEPTH):0]           level
);

   localparam int CW    = COMMIT_WIDTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = AW + 1;
   localparam int IDX_W = $clog2(CW + 1);
   localparam int CNT_W = $clog2(CW + 2);

   cosim_entry_t           mem_q [DEPTH];
   cosim_entry_t           slot_e [CW+1];
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          level_w, free_w;
   logic                   overflow_q, overflow_d;
   logic [CNT_W-1:0]       n_w;
   logic [CW:0][IDX_W-1:0] src_w;
   logic                   accept_w;
   logic [IDX_W-1:0]       pop_w;

   cosim_lane_compactor #(.CW(CW)) u_compact (
      .valid_i (in_valid),
      .xcpt_i  (in_xcpt),
      .n_o     (n_w),
      .src_o   (src_w)
   );

   // Build the entry for each dense slot from its source lane (or the trap).
   always_comb begin
      for (int s = 0; s <= CW; s++) begin
         slot_e[s] = '0;
         if (src_w[s] == IDX_W'(CW)) begin
            slot_e[s].is_trap = 1'b1;
            slot_e[s].wdata   = in_cause;
         end else begin
            for (int l = 0; l < CW; l++) begin
               if (src_w[s] == IDX_W'(l)) begin
                  slot_e[s].pc      = in_pc[l*XLEN +: XLEN];
                  slot_e[s].inst    = in_inst[l*INST_LEN +: INST_LEN];
                  slot_e[s].wdata   = in_wdata[l*XLEN +: XLEN];
                  slot_e[s].mstatus = in_mstatus[l*XLEN +: XLEN];
                  slot_e[s].check   = in_check[l];
               end
            end
         end
      end
   end

   // Pointers carry one extra bit so level is a plain subtraction.
   assign level_w  = wr_ptr_q - rd_ptr_q;
   assign free_w   = PW'(DEPTH) - level_w;
   // Admission looks at free space before this cycle's pops: all-or-nothing.
   assign accept_w = (PW'(n_w) <= free_w);

   always_ff @(posedge clock) begin
      if (reset && accept_w) begin
         for (int s = 0; s <= CW; s++)
            if (s < int'(n_w)) mem_q[AW'(wr_ptr_q + PW'(s))] <= slot_e[s];
      end
   end

   // Drain window: up to CW head entries, cut at the first trap so no commit
   // younger than the trap is presented with it.
   always_comb begin
      cosim_entry_t head;
      logic         trap_hit;
      head         = '0;
      trap_hit     = 1'b0;
      pop_w        = '0;
      out_valid    = '0;
      out_pc       = '0;
      out_inst     = '0;
      out_wdata    = '0;
      out_mstatus  = '0;
      out_check    = '0;
      out_int_xcpt = 1'b0;
      out_cause    = '0;
      for (int k = 0; k < CW; k++) begin
         head = mem_q[AW'(rd_ptr_q + PW'(k))];
         if (!trap_hit && (PW'(k) < level_w)) begin
            pop_w = pop_w + IDX_W'(1);
            if (head.is_trap) begin
               trap_hit     = 1'b1;
               out_int_xcpt = 1'b1;
               out_cause    = head.wdata;
            end else begin
               out_valid[k]                     = 1'b1;
               out_pc[k*XLEN +: XLEN]           = head.pc;
               out_inst[k*INST_LEN +: INST_LEN] = head.inst;
               out_wdata[k*XLEN +: XLEN]        = head.wdata;
               out_mstatus[k*XLEN +: XLEN]      = head.mstatus;
               out_check[k]                     = head.check;
            end
         end
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      if (accept_w) wr_ptr_d   = wr_ptr_q + PW'(n_w);
      else          overflow_d = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(pop_w);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_hartid = hartid;
   assign level      = level_w;
   assign overflow   = overflow_q;
   assign stall      = (free_w < PW'(CW + 1));

endmodule

// File: tb/tb_cosim_commit_queue.sv
module tb_cosim_commit_queue;

   localparam int CW    = 3;
   localparam int XL    = 64;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset;
   logic [CW-1:0]     in_valid, in_check;
   logic [XL*CW-1:0]  in_pc, in_wdata, in_mstatus;
   logic [32*CW-1:0]  in_inst;
   logic              in_xcpt;
   logic [XL-1:0]     in_cause, hartid;
   logic [CW-1:0]     out_valid, out_check;
   logic [XL-1:0]     out_hartid, out_cause;
   logic [XL*CW-1:0]  out_pc, out_wdata, out_mstatus;
   logic [32*CW-1:0]  out_inst;
   logic              out_int_xcpt, stall, overflow;
   logic [LW-1:0]     level;

   int total = 0;
   int bad   = 0;

   cosim_commit_queue #(.COMMIT_WIDTH(CW), .XLEN(XL), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata),
      .in_mstatus(in_mstatus), .in_check(in_check), .in_xcpt(in_xcpt), .in_cause(in_cause),
      .hartid(hartid),
      .out_valid(out_valid), .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst),
      .out_wdata(out_wdata), .out_mstatus(out_mstatus), .out_check(out_check),
      .out_int_xcpt(out_int_xcpt), .out_cause(out_cause),
      .stall(stall), .overflow(overflow), .level(level)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic [63:0] pc);
      in_pc[i*XL +: XL]      = pc;
      in_inst[i*32 +: 32]    = pc[31:0] ^ 32'h0000_0013;
      in_wdata[i*XL +: XL]   = {pc[31:0], ~pc[31:0]};
      in_mstatus[i*XL +: XL] = pc ^ 64'hA5A5_0000_0000_1800;
      in_check[i]            = pc[2];
   endtask

   task automatic clear_in();
      in_valid = '0; in_xcpt = 1'b0; in_cause = '0;
      in_pc = '0; in_inst = '0; in_wdata = '0; in_mstatus = '0; in_check = '0;
   endtask

   // ---------------- reference model: a plain queue of entries ----------------
   typedef struct {
      bit          trap;
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] wd;
      logic [63:0] ms;
      bit          chk;
   } ent_t;

   ent_t mq[$];
   bit   m_ovf;

   task automatic model_check(input string tag);
      logic [CW-1:0]    ev, ec;
      logic [XL*CW-1:0] ep, ew, em;
      logic [32*CW-1:0] ei;
      logic             ex;
      logic [63:0]      ecause;
      int               w;
      ev = '0; ec = '0; ep = '0; ew = '0; em = '0; ei = '0; ex = 1'b0; ecause = '0;
      w = (mq.size() < CW) ? mq.size() : CW;
      for (int k = 0; k < w; k++) begin
         if (mq[k].trap) begin
            ex = 1'b1; ecause = mq[k].wd;
            break;
         end
         ev[k] = 1'b1;
         ep[k*XL +: XL] = mq[k].pc;
         ei[k*32 +: 32] = mq[k].inst;
         ew[k*XL +: XL] = mq[k].wd;
         em[k*XL +: XL] = mq[k].ms;
         ec[k]          = mq[k].chk;
      end
      chk({tag, ".valid"},   out_valid, ev);
      chk({tag, ".xcpt"},    out_int_xcpt, ex);
      chk({tag, ".cause"},   out_cause, ecause);
      chk({tag, ".pc"},      out_pc, ep);
      chk({tag, ".inst"},    out_inst, ei);
      chk({tag, ".wdata"},   out_wdata, ew);
      chk({tag, ".mstatus"}, out_mstatus, em);
      chk({tag, ".check"},   out_check, ec);
      chk({tag, ".level"},   level, 256'(mq.size()));
      chk({tag, ".stall"},   stall, ((DEPTH - mq.size()) < CW + 1));
      chk({tag, ".ovf"},     overflow, m_ovf);
      chk({tag, ".hartid"},  out_hartid, hartid);
   endtask

   task automatic model_step();
      int   free, w, pops, n;
      ent_t e;
      if (!reset) begin
         mq.delete(); m_ovf = 1'b0;
         return;
      end
      free = DEPTH - mq.size();
      w    = (mq.size() < CW) ? mq.size() : CW;
      pops = 0;
      for (int k = 0; k < w; k++) begin
         pops++;
         if (mq[k].trap) break;
      end
      n = $countones(in_valid) + int'(in_xcpt);
      repeat (pops) void'(mq.pop_front());
      if (n > free) m_ovf = 1'b1;
      else begin
         for (int i = 0; i < CW; i++) begin
            if (in_valid[i]) begin
               e.trap = 1'b0;
               e.pc   = in_pc[i*XL +: XL];
               e.inst = in_inst[i*32 +: 32];
               e.wd   = in_wdata[i*XL +: XL];
               e.ms   = in_mstatus[i*XL +: XL];
               e.chk  = in_check[i];
               mq.push_back(e);
            end
         end
         if (in_xcpt) begin
            e.trap = 1'b1; e.pc = '0; e.inst = '0; e.wd = in_cause; e.ms = '0; e.chk = 1'b0;
            mq.push_back(e);
         end
      end
   endtask

   // outputs depend only on state, so checking after inputs change is safe
   task automatic cyc(input string tag);
      model_check(tag);
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic burst(input logic [63:0] base);
      clear_in();
      in_valid = 3'b111;
      for (int i = 0; i < CW; i++) set_lane(i, base + 64'(4*i));
      in_xcpt  = 1'b1;
      in_cause = base ^ 64'h8000_0000_0000_0000;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          rst_n;
      logic [2:0]  v;
      bit          x;
      logic [63:0] pc0, pc2, cause;
      logic [2:0]  e_v;
      bit          e_x;
      logic [63:0] e_pc0, e_pc1, e_cause;
      int          e_lvl;
      bit          e_stall;
   } vec_t;

   function automatic vec_t mkv(bit r, logic [2:0] v, bit x, logic [63:0] p0, logic [63:0] p2,
                                logic [63:0] c, logic [2:0] ev, bit ex, logic [63:0] ep0,
                                logic [63:0] ep1, logic [63:0] ec, int el);
      vec_t t;
      t.rst_n = r; t.v = v; t.x = x; t.pc0 = p0; t.pc2 = p2; t.cause = c;
      t.e_v = ev; t.e_x = ex; t.e_pc0 = ep0; t.e_pc1 = ep1; t.e_cause = ec; t.e_lvl = el;
      t.e_stall = 1'b0;
      return t;
   endfunction

   localparam int NV = 7;
   vec_t tv [NV];

   logic [63:0] last_pc;
   int          seen;
   bit          mono;

   task automatic scan();
      for (int k = 0; k < CW; k++) begin
         if (out_valid[k]) begin
            if (seen > 0 && out_pc[k*XL +: XL] <= last_pc) mono = 1'b0;
            last_pc = out_pc[k*XL +: XL];
            seen++;
         end
      end
   endtask

   initial begin
      tv[0] = mkv(0, 3'b111, 0, 64'h10, 64'h18, 0, 3'b000, 0, 0, 0, 0, 0);
      tv[1] = mkv(0, 3'b111, 0, 64'h10, 64'h18, 0, 3'b000, 0, 0, 0, 0, 0);
      tv[2] = mkv(1, 3'b101, 0, 64'h8000_0000, 64'h8000_0008, 0,
                  3'b011, 0, 64'h8000_0000, 64'h8000_0008, 0, 2);
      tv[3] = mkv(1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
      tv[4] = mkv(1, 3'b001, 1, 64'h100, 0, 64'h8000_0000_0000_0007,
                  3'b001, 1, 64'h100, 0, 64'h8000_0000_0000_0007, 2);
      tv[5] = mkv(1, 3'b001, 0, 64'h200, 0, 0, 3'b001, 0, 64'h200, 0, 0, 1);
      tv[6] = mkv(1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

      hartid = 64'h3;
      reset  = 1'b0;
      clear_in();
      @(negedge clock);

      for (int r = 0; r < NV; r++) begin
         reset = tv[r].rst_n;
         clear_in();
         in_valid = tv[r].v;
         set_lane(0, tv[r].pc0);
         set_lane(1, tv[r].pc0 + 64'h4);
         set_lane(2, tv[r].pc2);
         in_xcpt  = tv[r].x;
         in_cause = tv[r].cause;
         @(posedge clock);
         @(negedge clock);
         chk($sformatf("tbl%0d.valid", r), out_valid, tv[r].e_v);
         chk($sformatf("tbl%0d.xcpt", r),  out_int_xcpt, tv[r].e_x);
         chk($sformatf("tbl%0d.cause", r), out_cause, tv[r].e_cause);
         chk($sformatf("tbl%0d.pc0", r),   out_pc[0 +: XL], tv[r].e_pc0);
         chk($sformatf("tbl%0d.pc1", r),   out_pc[XL +: XL], tv[r].e_pc1);
         chk($sformatf("tbl%0d.level", r), level, 256'(tv[r].e_lvl));
         chk($sformatf("tbl%0d.ovf", r),   overflow, 1'b0);
         chk($sformatf("tbl%0d.stall", r), stall, tv[r].e_stall);
      end

      // ---- saturate: 4 entries in, at most 3 out per cycle ----
      reset = 1'b0; clear_in(); cyc("t4rst");
      reset = 1'b1;
      for (int c = 0; c < 14; c++) begin
         burst(64'h4000 + 64'(16*c));
         cyc("t4");
      end
      chk("t4.overflow_seen", overflow, 1'b1);
      clear_in();
      for (int c = 0; c < 20; c++) cyc("t4drain");
      chk("t4.drained", level, 0);

      // ---- reach level 9, then reset mid-stream ----
      for (int c = 0; c < 4; c++) begin
         burst(64'h9000 + 64'(16*c));
         cyc("t6fill");
      end
      chk("t6.level9", level, 9);
      chk("t6.ovf_before", overflow, 1'b1);
      burst(64'hA000);
      reset = 1'b0;
      cyc("t6rst");
      chk("t6.level0", level, 0);
      chk("t6.valid0", out_valid, 0);
      chk("t6.ovf0", overflow, 1'b0);
      chk("t6.stall0", stall, 1'b0);
      reset = 1'b1;
      clear_in();
      in_valid = 3'b010;
      set_lane(1, 64'hABC0);
      cyc("t6in");
      chk("t6.after_valid", out_valid, 3'b001);
      chk("t6.after_pc", out_pc[0 +: XL], 64'hABC0);
      chk("t6.after_inst", out_inst[0 +: 32], 32'h0000_ABD3);
      clear_in();
      cyc("t6idle");

      // ---- 40 single-lane commits across pointer wraps ----
      seen = 0; mono = 1'b1; last_pc = '0;
      for (int k = 0; k < 40; k++) begin
         clear_in();
         begin
            int ln;
            ln = $urandom_range(0, CW - 1);
            in_valid[ln] = 1'b1;
            set_lane(ln, 64'h1000 + 64'(4*k));
         end
         scan();
         cyc("t5");
         if ($urandom_range(0, 3) == 0) begin
            clear_in(); scan(); cyc("t5gap");
         end
      end
      clear_in();
      for (int c = 0; c < 6; c++) begin
         scan(); cyc("t5drain");
      end
      chk("t5.count", seen, 40);
      chk("t5.monotonic", mono, 1'b1);
      chk("t5.ovf", overflow, 1'b0);

      // ---- random traffic against the model ----
      for (int c = 0; c < 400; c++) begin
         clear_in();
         reset = ($urandom_range(0, 79) != 0);
         if ((c / 50) % 2 == 0) in_valid = 3'($urandom);
         else                   in_valid = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         for (int i = 0; i < CW; i++) begin
            in_pc[i*XL +: XL]      = {$urandom, $urandom};
            in_inst[i*32 +: 32]    = $urandom;
            in_wdata[i*XL +: XL]   = {$urandom, $urandom};
            in_mstatus[i*XL +: XL] = {$urandom, $urandom};
            in_check[i]            = 1'($urandom);
         end
         in_xcpt  = ($urandom_range(0, 4) == 0);
         in_cause = {$urandom, $urandom};
         cyc("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
